// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Fetch addresses are always word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_seq_ctrl_watchdog.sv
// Fetch timeout counter: counts consecutive waiting request cycles and
// flags the cycle in which the MAX_WAIT-th wait cycle occurs.
module fetch_watchdog #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   output logic timeout
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   logic [CW-1:0] cnt;

   assign timeout = waiting && (cnt == CW'(MAX_WAIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!waiting || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: owns the PC and the imem req/ack handshake.
// Optional fetch timeout is enabled with the FETCH_TIMEOUT_EN macro.
//
// Handshake: imem_req is high in every S_REQ cycle and imem_addr (= pc) is
// held stable until a cycle in which imem_ack is high; that cycle completes
// the transfer. inst_valid stays high until decode consumes (no stall_hz)
// or a redirect drops the instruction.
module fetch_seq_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   input  logic        stall_hz,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic [31:0] pc,
   output logic        stall_miss,
   output logic        err,
   output logic [1:0]  state_dbg
);

   fetch_state_t state, state_nx;
   logic [31:0]  pc_nx, inst_out_nx, inst_pc_nx, pend_pc, pend_pc_nx;
   logic         inst_valid_nx, kill, kill_nx;
   logic         timeout;
   logic [31:0]  redir;

   assign redir      = align_pc(redirect_addr);
   assign imem_req   = (state == S_REQ);
   assign imem_addr  = pc;
   assign stall_miss = (state == S_REQ) && !imem_ack;
   assign state_dbg  = state;

`ifdef FETCH_TIMEOUT_EN
   logic err_q;

   fetch_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .waiting (stall_miss),
      .timeout (timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= timeout;
   end
   assign err = err_q;
`else
   logic [31:0] unused_max_wait;
   assign unused_max_wait = MAX_WAIT;
   assign timeout         = 1'b0;
   assign err             = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_BOOT;
         pc         <= RESET_PC;
         inst_valid <= 1'b0;
         inst_out   <= INST_NOP;
         inst_pc    <= '0;
         kill       <= 1'b0;
         pend_pc    <= '0;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         inst_valid <= inst_valid_nx;
         inst_out   <= inst_out_nx;
         inst_pc    <= inst_pc_nx;
         kill       <= kill_nx;
         pend_pc    <= pend_pc_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      inst_valid_nx = inst_valid;
      inst_out_nx   = inst_out;
      inst_pc_nx    = inst_pc;
      kill_nx       = kill;
      pend_pc_nx    = pend_pc;
      case (state)
         S_BOOT: begin
            if (redirect_valid) pc_nx = redir;
            state_nx = S_REQ;
         end
         S_REQ: begin
            if (imem_ack) begin
               // A redirect alongside ack is newer than any pending one.
               if (redirect_valid) begin
                  pc_nx   = redir;
                  kill_nx = 1'b0;
               end else if (kill) begin
                  pc_nx   = pend_pc;
                  kill_nx = 1'b0;
               end else begin
                  inst_out_nx   = imem_rdata;
                  inst_pc_nx    = pc;
                  inst_valid_nx = 1'b1;
                  state_nx      = S_HOLD;
               end
            end else begin
               // Address must stay stable, so remember the target for later.
               if (redirect_valid) begin
                  kill_nx    = 1'b1;
                  pend_pc_nx = redir;
               end
               if (timeout) state_nx = S_BOOT;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nx         = redir;
               inst_valid_nx = 1'b0;
               state_nx      = S_REQ;
            end else if (!stall_hz) begin
               pc_nx         = pc + PC_STEP;
               inst_valid_nx = 1'b0;
               state_nx      = S_REQ;
            end
         end
         default: state_nx = S_BOOT;
      endcase
   end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: reset, sequential fetch, hazard stall,
// redirects during and with ack, PC wrap, reset mid-fetch, optional timeout.
module tb_fetch_seq_ctrl;
   import fetch_pkg::*;

   localparam int TB_MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        stall_hz;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic [31:0] pc;
   logic        stall_miss;
   logic        err;
   logic [1:0]  state_dbg;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fetch_seq_ctrl #(.RESET_PC(32'h0000_0000), .MAX_WAIT(TB_MAX_WAIT)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .stall_hz       (stall_hz),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_out       (inst_out),
      .inst_pc        (inst_pc),
      .pc             (pc),
      .stall_miss     (stall_miss),
      .err            (err),
      .state_dbg      (state_dbg)
   );

   // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic rv, input logic [31:0] ra, input logic sh,
                         input logic ack, input logic [31:0] rd);
      redirect_valid = rv;
      redirect_addr  = ra;
      stall_hz       = sh;
      imem_ack       = ack;
      imem_rdata     = rd;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      chk("rst_req",        {31'd0, imem_req},   32'd0);
      chk("rst_pc",         pc,                  32'h0);
      chk("rst_valid",      {31'd0, inst_valid}, 32'd0);
      chk("rst_inst_out",   inst_out,            32'h0000_0013);
      chk("rst_inst_pc",    inst_pc,             32'h0);
      chk("rst_stall_miss", {31'd0, stall_miss}, 32'd0);
      chk("rst_err",        {31'd0, err},        32'd0);
      chk("rst_state",      {30'd0, state_dbg},  {30'd0, S_BOOT});

      // Boot: one idle cycle, then request at address 0 acked immediately.
      rst = 1'b0;
      #1;
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("req0_req",  {31'd0, imem_req}, 32'd1);
      chk("req0_addr", imem_addr, 32'h0);
      chk("req0_miss", {31'd0, stall_miss}, 32'd1);
      set_in(1'b0, '0, 1'b0, 1'b1, 32'hA000_0000);
      chk("req0_miss_ack", {31'd0, stall_miss}, 32'd0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("hold0_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold0_inst",  inst_out, 32'hA000_0000);
      chk("hold0_pc",    inst_pc, 32'h0);
      chk("hold0_req",   {31'd0, imem_req}, 32'd0);
      tick();
      chk("req4_addr",  imem_addr, 32'h4);
      chk("req4_valid", {31'd0, inst_valid}, 32'd0);

      // Hazard stall held for three cycles in S_HOLD.
      set_in(1'b0, '0, 1'b0, 1'b1, 32'hA000_0004);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, '0, 1'b1, 1'b0, '0);
         chk("stall_valid", {31'd0, inst_valid}, 32'd1);
         chk("stall_inst",  inst_out, 32'hA000_0004);
         chk("stall_pc",    inst_pc, 32'h4);
         chk("stall_req",   {31'd0, imem_req}, 32'd0);
         tick();
      end
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("stall_still_held", inst_pc, 32'h4);
      tick();
      chk("after_stall_addr", imem_addr, 32'h8);
      chk("after_stall_req",  {31'd0, imem_req}, 32'd1);

      // Redirect to 0x100 two cycles before a delayed ack at address 8.
      set_in(1'b1, 32'h0000_0100, 1'b0, 1'b0, '0);
      chk("kill_miss0", {31'd0, stall_miss}, 32'd1);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("kill_miss1", {31'd0, stall_miss}, 32'd1);
      chk("kill_addr_hold", imem_addr, 32'h8);
      tick();
      chk("kill_miss2", {31'd0, stall_miss}, 32'd1);
      set_in(1'b0, '0, 1'b0, 1'b1, 32'hDEAD_0008);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("kill_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("kill_new_addr", imem_addr, 32'h100);
      chk("kill_new_req",  {31'd0, imem_req}, 32'd1);

      // Redirect coincident with ack; low address bits are dropped.
      set_in(1'b1, 32'h0000_0203, 1'b0, 1'b1, 32'hBAD0_0100);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("rdack_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("rdack_addr",     imem_addr, 32'h200);

      // Redirect from S_HOLD to the top of memory, then wrap on consume.
      set_in(1'b0, '0, 1'b0, 1'b1, 32'hC000_0200);
      tick();
      chk("hold200_pc", inst_pc, 32'h200);
      set_in(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("hold_rd_valid", {31'd0, inst_valid}, 32'd0);
      chk("hold_rd_addr",  imem_addr, 32'hFFFF_FFFC);
      set_in(1'b0, '0, 1'b0, 1'b1, 32'hE000_FFFC);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("top_inst_pc", inst_pc, 32'hFFFF_FFFC);
      chk("top_inst",    inst_out, 32'hE000_FFFC);
      tick();
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset mid-fetch, then a redirect and stray ack while booting.
      rst = 1'b1;
      #1;
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst = 1'b0;
      set_in(1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'h1111_1111);
      chk("bootrd_req", {31'd0, imem_req}, 32'd0);
      tick();
      set_in(1'b0, '0, 1'b0, 1'b0, '0);
      chk("bootrd_valid", {31'd0, inst_valid}, 32'd0);
      chk("bootrd_addr",  imem_addr, 32'h40);
      chk("bootrd_inst",  inst_out, 32'h0000_0013);

`ifdef FETCH_TIMEOUT_EN
      // No ack: err pulses after MAX_WAIT waiting cycles, then re-request.
      for (int i = 1; i < TB_MAX_WAIT; i++) begin
         tick();
         chk("to_wait_err", {31'd0, err}, 32'd0);
         chk("to_wait_req", {31'd0, imem_req}, 32'd1);
      end
      tick();
      chk("to_err_pulse", {31'd0, err}, 32'd1);
      chk("to_req_low",   {31'd0, imem_req}, 32'd0);
      tick();
      chk("to_err_clear", {31'd0, err}, 32'd0);
      chk("to_rereq",     {31'd0, imem_req}, 32'd1);
      chk("to_addr",      imem_addr, 32'h40);
`else
      // Without the timeout the fetch waits indefinitely.
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("nto_err", {31'd0, err}, 32'd0);
      end
      chk("nto_req",  {31'd0, imem_req}, 32'd1);
      chk("nto_addr", imem_addr, 32'h40);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It applies redirect, hazard stall and sequential advance in fixed priority, and handles redirects that arrive while a fetch is outstanding. It presents fetched instructions to decode and exports a memory-wait stall flag for the rest of the pipeline.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, cycles without ack before timeout (only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
redirect_valid  in  1  branch/jump taken this cycle
redirect_addr  in  32  redirect target; bits [1:0] forced to 0
stall_hz  in  1  downstream hazard; instruction not consumed
imem_req  out  1  fetch request; held until ack
imem_addr  out  32  fetch address, equals pc
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction
inst_valid  out  1  inst_out/inst_pc valid
inst_out  out  32  instruction to decode
inst_pc  out  32  address of inst_out
pc  out  32  current fetch PC
stall_miss  out  1  waiting on memory: (state==S_REQ) && !imem_ack
err  out  1  one-cycle fetch-timeout pulse

Behaviour:
- Reset (async): state=S_BOOT, pc=RESET_PC, imem_req=0, inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=0, err=0, kill=0, pend_pc=0. stall_miss=0.
- S_BOOT: imem_req=0 for exactly one cycle, then S_REQ. A redirect in S_BOOT loads pc=redirect_addr.
- S_REQ: imem_req=1 and imem_addr=pc. imem_addr stays stable until ack.
  - ack, kill=0, no redirect: capture inst_out=imem_rdata and inst_pc=pc; set inst_valid=1; go to S_HOLD. pc does not change.
  - ack together with redirect_valid: discard data, pc=redirect_addr, stay in S_REQ. The new address is driven on the next cycle.
  - ack with kill=1: discard data, pc=pend_pc, kill=0, stay in S_REQ.
  - redirect without ack: kill=1, pend_pc=redirect_addr. If several redirects arrive, the last one wins.
- S_HOLD: imem_req=0. Priority is redirect > stall_hz > advance.
  - redirect_valid: pc=redirect_addr, inst_valid=0, go to S_REQ. The held instruction is dropped.
  - stall_hz=1: hold all outputs.
  - otherwise the instruction is consumed this cycle: pc=pc+4, inst_valid=0, go to S_REQ.
- Throughput: one instruction per two cycles with zero-wait memory; latency from request to inst_valid is one cycle after ack.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- stall_hz is ignored in S_BOOT and S_REQ.
- Reset mid-fetch drops imem_req immediately; any later ack is ignored because state is S_BOOT.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: a wait counter increments each S_REQ cycle without ack and clears on ack or on leaving S_REQ. When the counter reaches MAX_WAIT:
  - err pulses for one cycle;
  - the FSM goes to S_BOOT (imem_req low for one cycle) and then reissues the same pc;
  - kill and pend_pc are preserved.
- Undefined: no counter; the FSM waits for ack indefinitely; err is tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - state encoding S_BOOT, S_REQ, S_HOLD;
  - INST_NOP = 32'h0000_0013;
  - PC_STEP = 4;
  - default RESET_PC.
- One sub-module is natural: fetch_watchdog, the timeout counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release with RESET_PC=0 and ack on the first request cycle -> imem_req rises one cycle after reset; imem_addr=0; inst_valid=1 the next cycle with inst_pc=0; the next request goes to addr 4.
- stall_hz held for 3 cycles while in S_HOLD -> inst_out/inst_pc stable, imem_req=0; after release, imem_addr advances by 4.
- Redirect to 32'h100 two cycles before a delayed ack at addr 8 -> no inst_valid for addr 8; the next request goes to 32'h100; stall_miss=1 throughout the wait.
- Redirect to 32'h200 coincident with ack -> data discarded; next imem_addr=32'h200.
- pc=32'hFFFF_FFFC, ack, then consume -> next imem_addr=0.
- FETCH_TIMEOUT_EN with MAX_WAIT=15 and no ack -> err pulses after 15 cycles, imem_req low for 1 cycle, then a re-request at the same address.
